// File: rtl/ifeed_skew.sv
// West-border row feeder: buffers ROWS-wide input vectors in a small FIFO and
// emits them diagonally skewed (lane r delayed r cycles) with per-lane en/clr.
module ifeed_skew #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*WIDTH-1:0]   in_data,
  input  logic                    in_last,
  input  logic                    stall,
  output logic [ROWS*WIDTH-1:0]   o_data,
  output logic [ROWS-1:0]         o_en,
  output logic [ROWS-1:0]         o_clr,
  output logic                    busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = ROWS*WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  state_t        state_q, state_d;

  logic          push, pop, empty, full, pop_last, gap_clr;
  logic [EW-1:0] rd_entry;
  logic [ROWS-1:0] lane_busy;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign rd_entry = mem_q[rptr_q];
  assign pop_last = rd_entry[EW-1];
  // IDLE with a non-empty FIFO behaves as RUN, so the first pop needs no extra cycle.
  assign pop      = !stall && (state_q != GAP) && !empty;
  assign gap_clr  = !stall && (state_q == GAP);

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr_q] = {in_last, in_data};
    wptr_d = wptr_q + AW'(push);
    rptr_d = rptr_q + AW'(pop);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        IDLE, RUN: begin
          if (pop) state_d = pop_last ? GAP : RUN;
          else     state_d = IDLE;
        end
        GAP:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic signed [WIDTH-1:0] dat_q [r+1];
    logic signed [WIDTH-1:0] dat_d [r+1];
    logic [r:0] en_q, en_d, clr_q, clr_d;

    always_comb begin
      dat_d = dat_q;
      en_d  = en_q;
      clr_d = clr_q;
      if (!stall) begin
        dat_d[0] = pop ? rd_entry[r*WIDTH +: WIDTH] : '0;
        en_d[0]  = pop;
        clr_d[0] = gap_clr;
        for (int k = 1; k <= r; k++) begin
          dat_d[k] = dat_q[k-1];
          en_d[k]  = en_q[k-1];
          clr_d[k] = clr_q[k-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) dat_q[k] <= '0;
        en_q  <= '0;
        clr_q <= '0;
      end else begin
        for (int k = 0; k <= r; k++) dat_q[k] <= dat_d[k];
        en_q  <= en_d;
        clr_q <= clr_d;
      end
    end

    // Held en/clr stay in the chain during stall and are only masked at the output.
    assign o_data[r*WIDTH +: WIDTH] = dat_q[r];
    assign o_en[r]      = en_q[r] & ~stall;
    assign o_clr[r]     = clr_q[r] & ~stall;
    assign lane_busy[r] = (|en_q) | (|clr_q);
  end

  assign busy = !empty || (|lane_busy) || (state_q != IDLE);

endmodule

// File: tb/tb_ifeed_skew.sv
// Scoreboard bench for ifeed_skew: per-lane expected en/clr events are queued at
// each accepted push and consumed as the skewed outputs appear.
module tb_ifeed_skew;
  localparam int WIDTH = 8;
  localparam int ROWS  = 4;
  localparam int DEPTH = 4;

  logic clk = 0;
  logic rst, in_valid, in_ready, in_last, stall, busy;
  logic [ROWS*WIDTH-1:0] in_data, o_data;
  logic [ROWS-1:0] o_en, o_clr;

  ifeed_skew #(.WIDTH(WIDTH), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .stall(stall),
    .o_data(o_data), .o_en(o_en), .o_clr(o_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int en_seen = 0;
  int en_exp = 0;
  bit mon_en = 0;
  logic [WIDTH:0] sbq [ROWS][$];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] lane(input logic [ROWS*WIDTH-1:0] v, input int r);
    return v[r*WIDTH +: WIDTH];
  endfunction

  function automatic logic [ROWS*WIDTH-1:0] mk(input int base);
    logic [ROWS*WIDTH-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*WIDTH +: WIDTH] = WIDTH'(base + r);
    return v;
  endfunction

  task automatic sb_add(input logic [ROWS*WIDTH-1:0] v, input logic last);
    for (int r = 0; r < ROWS; r++) begin
      sbq[r].push_back({1'b0, v[r*WIDTH +: WIDTH]});
      if (last) sbq[r].push_back({1'b1, {WIDTH{1'b0}}});
    end
    en_exp += ROWS;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_vec(input logic [ROWS*WIDTH-1:0] v, input logic last);
    bit done;
    done = 0;
    in_data = v; in_last = last; in_valid = 1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_add(v, last);
        step();
        done = 1;
      end
    end
    in_valid = 0; in_last = 0;
    if (!done) chk_eq("push_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int n = 0; n < 100 && !idle; n++) begin
      @(negedge clk);
      if (!busy) idle = 1;
      step();
    end
    if (!idle) chk_eq("drain_timeout", 1, 0);
  endtask

  // Output monitor: every en/clr must match the head of its lane's queue.
  always @(negedge clk) begin
    if (mon_en) begin
      chk_eq("en_clr_overlap", o_en & o_clr, 0);
      for (int r = 0; r < ROWS; r++) begin
        if (o_en[r] || o_clr[r]) begin
          if (sbq[r].size() == 0) begin
            chk_eq("sb_extra_event", {o_en[r], o_clr[r]}, 0);
          end else begin
            logic [WIDTH:0] e;
            e = sbq[r].pop_front();
            chk_eq("sb_kind_clr", o_clr[r], e[WIDTH]);
            chk_eq("sb_data", lane(o_data, r), e[WIDTH-1:0]);
            if (o_en[r]) en_seen++;
          end
        end else if (!stall) begin
          chk_eq("bubble_data", lane(o_data, r), 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [ROWS*WIDTH-1:0] v;
    rst = 1; in_valid = 0; in_data = '0; in_last = 0; stall = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_eq("rst_en", o_en, 0);
    chk_eq("rst_clr", o_clr, 0);
    chk_eq("rst_data", o_data, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_ready", in_ready, 1);
    mon_en = 1;
    step();

    // Single vector with last: latency and per-lane skew
    fork
      push_vec(mk(1), 1);
      begin
        for (int c = 0; c < 9; c++) begin
          @(negedge clk);
          for (int r = 0; r < ROWS; r++) begin
            chk_eq("t1_en", o_en[r], (c == 2 + r));
            chk_eq("t1_clr", o_clr[r], (c == 3 + r));
            chk_eq("t1_data", lane(o_data, r), (c == 2 + r) ? r + 1 : 0);
          end
          chk_eq("t1_busy", busy, (c >= 1 && c <= 6));
        end
      end
    join
    step();
    wait_idle();

    // Back-to-back tiles A(3) and B(2)
    fork
      begin
        push_vec(mk(16), 0); push_vec(mk(32), 0); push_vec(mk(48), 1);
        push_vec(mk(64), 0); push_vec(mk(80), 1);
      end
      begin
        for (int c = 0; c < 9; c++) begin
          logic e_en, e_clr;
          logic [WIDTH-1:0] e_d;
          @(negedge clk);
          e_en = 0; e_clr = 0; e_d = '0;
          if (c >= 2 && c <= 4) begin e_en = 1; e_d = WIDTH'(16 * (c - 1)); end
          if (c == 5 || c == 8) e_clr = 1;
          if (c == 6) begin e_en = 1; e_d = 8'd64; end
          if (c == 7) begin e_en = 1; e_d = 8'd80; end
          chk_eq("t2_en0", o_en[0], e_en);
          chk_eq("t2_clr0", o_clr[0], e_clr);
          chk_eq("t2_data0", lane(o_data, 0), e_d);
        end
      end
    join
    step();
    wait_idle();

    // Fill under stall, then release; order kept across pointer wrap
    stall = 1;
    push_vec(mk(8'h60), 0); push_vec(mk(8'h70), 0);
    push_vec(mk(8'h90), 0); push_vec(mk(8'hA0), 0);
    @(negedge clk);
    chk_eq("fill_ready_full", in_ready, 0);
    step();
    stall = 0; v = mk(8'hB0); in_data = v; in_last = 1; in_valid = 1;
    @(negedge clk);
    chk_eq("fill_no_bypass", in_ready, 0);
    step();
    @(negedge clk);
    chk_eq("fill_ready_after_pop", in_ready, 1);
    if (in_ready) sb_add(v, 1);
    step();
    in_valid = 0; in_last = 0;
    wait_idle();

    // Stall mid-skew with extreme signed values on lanes 0 and 3
    v = {8'h7F, 8'h22, 8'h11, 8'h80};
    push_vec(v, 1);
    step();
    @(negedge clk);
    chk_eq("neg_en0", o_en[0], 1);
    chk_eq("neg_lane0", lane(o_data, 0), 8'h80);
    step();
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("stall_en", o_en, 0);
      chk_eq("stall_clr", o_clr, 0);
      chk_eq("stall_hold_lane2", lane(o_data, 2), 8'h22);
      step();
    end
    stall = 0;
    @(negedge clk);
    chk_eq("unstall_en2", o_en[2], 1);
    chk_eq("unstall_lane2", lane(o_data, 2), 8'h22);
    step();
    @(negedge clk);
    chk_eq("pos_en3", o_en[3], 1);
    chk_eq("pos_lane3", lane(o_data, 3), 8'h7F);
    step();
    wait_idle();
    chk_eq("en_total", en_seen, en_exp);
    for (int r = 0; r < ROWS; r++) chk_eq("sb_left", sbq[r].size(), 0);

    // Reset while a tile is half drained
    push_vec(mk(8'h40), 0); push_vec(mk(8'h44), 0); push_vec(mk(8'h50), 1);
    step();
    rst = 1;
    step();
    rst = 0;
    for (int r = 0; r < ROWS; r++) sbq[r].delete();
    @(negedge clk);
    chk_eq("mid_rst_en", o_en, 0);
    chk_eq("mid_rst_clr", o_clr, 0);
    chk_eq("mid_rst_data", o_data, 0);
    chk_eq("mid_rst_busy", busy, 0);
    chk_eq("mid_rst_ready", in_ready, 1);
    repeat (10) step();
    @(negedge clk);
    chk_eq("post_rst_busy", busy, 0);

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifeed_skew.md
Name: ifeed_skew

Overview:
- Row-input feeder directly upstream of the west-border input registers of the systolic array.
- Accepts one ROWS-wide input vector per handshake into a small FIFO, then pops it into a diagonal skew so lane r is presented r cycles after lane 0.
- Drives each border register's i_data, en and clr.
- Marks tile boundaries with a skewed per-lane clear and inserts a one-cycle gap between tiles.

Parameters:
- WIDTH, 8: signed element width.
- ROWS, 4: number of array rows (lanes); at least 1.
- DEPTH, 4: input FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream vector valid.
- in_ready  out  1  FIFO can accept; equals !full, with no same-cycle pop bypass.
- in_data  in  ROWS*WIDTH  signed lanes; lane r occupies bits [r*WIDTH +: WIDTH].
- in_last  in  1  vector is the last of its tile.
- stall  in  1  array backpressure; freezes the block.
- o_data  out  ROWS*WIDTH  to border i_data, per lane.
- o_en  out  ROWS  per-lane border enable.
- o_clr  out  ROWS  per-lane border clear.
- busy  out  1  FIFO non-empty, OR any skew stage holds en/clr, OR state != IDLE.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - FIFO emptied; pointers and count are 0.
  - All skew stages: data=0, en=0, clr=0.
  - State goes to IDLE.
  - From the next cycle: o_data=0, o_en=0, o_clr=0, busy=0, in_ready=1.
  - Reset mid-tile discards all in-flight data; no clr is emitted.
- Push: occurs when in_valid && in_ready. {in_data, in_last} are written at that edge.
  - The entry becomes poppable in the following cycle; there is no bypass.
- Pop condition: !stall && state==RUN && FIFO non-empty.
- Simultaneous push and pop with FIFO not full: count is unchanged, and both pointers advance and wrap modulo DEPTH.
- FSM:
  - IDLE -> RUN when the FIFO is non-empty and !stall. The pop may occur in the same cycle as the transition; the FSM treats IDLE with a non-empty FIFO as RUN.
  - RUN, pop with last=1 -> GAP.
  - RUN, FIFO empty -> IDLE.
  - GAP -> RUN after exactly one non-stalled cycle. No pop occurs in GAP.
  - stall freezes the state.
- Skew pipeline, per lane r: a chain of r+1 registers carrying {data, en, clr}.
  - On a pop at edge p, stage 0 of every lane loads {lane data, en=1, clr=0}.
  - On the edge after a pop with last=1, stage 0 of every lane loads {0, en=0, clr=1}.
  - On any other non-stalled edge, stage 0 loads {0, 0, 0}.
  - Every stage shifts one step per non-stalled edge.
  - Lane r output is the tail of its chain. Lane 0 is valid in cycle p+1; lane r is valid in cycle p+1+r.
- Because of the GAP, o_en[r] and o_clr[r] are never both 1. The clr on lane r lands one cycle after that lane's last element.
- Stall: all registers (FIFO pointers, FSM, skew chain) hold.
  - o_en and o_clr are combinationally forced to 0 while stall=1.
  - o_data still shows the held tail values.
  - After stall deasserts, the held en/clr values are presented again; nothing is lost or duplicated.
  - Pushes are still accepted during stall if !full.
- Data is passed unmodified, with no arithmetic. Bubbles output o_data=0.
- Latency from a handshake into an empty, idle, unstalled block: lane r outputs at handshake cycle + 2 + r.
- Throughput: one vector per cycle sustained within a tile.

Test Plan:
- ROWS=4, rst then one push of lanes {1,2,3,4} with last=1 at cycle 0 -> o_en[0]=1 with o_data lane0=1 at cycle 2. Lane r appears at cycle 2+r with value r+1. o_clr[r]=1 at cycle 3+r. busy=0 from cycle 7.
- Back-to-back tiles: A=3 vectors (last on the 3rd), B=2 vectors, pushed every cycle -> lane 0 shows en for A0..A2 in cycles 2-4, then clr in cycle 5, then B0 in cycle 6. en and clr never overlap on any lane.
- Fill: hold stall=1 and push 5 vectors -> in_ready goes 0 after 4 accepted. The 5th is accepted the cycle after stall drops and the first pop occurs. Order is preserved through a pointer wrap.
- Stall mid-skew: stall=1 for 3 cycles while lane 2 holds pending en -> o_en=0 and o_clr=0 during stall. Lane 2 en is re-presented in the first unstalled cycle with the same data; the total en count equals the number of vectors × ROWS.
- rst asserted while the tile is half-drained -> next cycle o_en=0, o_clr=0, o_data=0, busy=0. No clr appears afterwards.
- Negative data 8'h80/8'h7F on lanes 0/3 -> same bit patterns appear on o_data at the skewed cycles.
